axis_burst_checker: RTL and testbench
=====================================

# axis_burst_checker

Synthesizable AXI4-Stream sink that receives one fixed-length burst from an AXI-Stream master, such as the counting-pattern generator on our IP's m00_axis port. It compares each beat against an incrementing expected pattern (base + beat index) and checks TLAST placement. Results are held in status outputs, and every received word is stored for indexed readback. It lets the stream master be checked on hardware or in a standalone bench without the behavioural receive task.

## Interface
- DATA_WIDTH, 32, width of tdata and of the expected base
- BURST_LEN, 8, beats per burst (2..255)
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that arms the checker
- expected_base  in  DATA_WIDTH  value expected on beat 0, sampled when start is accepted
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tstrb  in  DATA_WIDTH/8  byte strobes; ignored
- s_axis_tlast  in  1  end of burst marker
- busy  out  1  high while in RECEIVE
- done  out  1  sticky; burst complete
- pass  out  1  done, no data errors, no TLAST error
- error_count  out  8  data mismatches in the burst, saturating at 255
- first_error_index  out  8  beat index of the first data mismatch; BURST_LEN if none
- tlast_error  out  1  TLAST missing on the last beat or asserted early
- beat_count  out  8  beats accepted so far
- rd_index  in  8  capture-memory read index
- rd_data  out  DATA_WIDTH  captured beat[rd_index], combinational; 0 if rd_index >= BURST_LEN

## Operation
- States: IDLE, RECEIVE, DONE.
- IDLE
  - start -> RECEIVE.
  - Latch expected_base.
  - Clear beat_count, error_count, tlast_error and done.
  - Set first_error_index = BURST_LEN.
- RECEIVE
  - s_axis_tready = 1.
  - A beat is accepted when tvalid && tready.
  - On each accepted beat k (k = beat_count):
    - Store tdata in mem[k].
    - If tdata != (base + k) mod 2^DATA_WIDTH, increment error_count (saturating). If this is the first mismatch, set first_error_index = k.
    - If tlast != (k == BURST_LEN-1), set tlast_error. It is sticky for the burst.
    - Increment beat_count.
  - Accepting beat BURST_LEN-1 moves the state to DONE. An early TLAST does not end the burst: exactly BURST_LEN beats are always consumed.
- DONE
  - done = 1; all status outputs hold.
  - start -> RECEIVE with the same clearing as in IDLE.
- start is ignored while in RECEIVE.
- pass = done && error_count == 0 && !tlast_error.
- busy = (state == RECEIVE).
- Capture memory is not cleared by start. It is overwritten beat by beat.

## Timing
- Reset (ARESETN low, asynchronous):
  - State goes to IDLE.
  - s_axis_tready, busy, done, pass, tlast_error = 0.
  - error_count, beat_count = 0.
  - first_error_index = BURST_LEN.
  - Memory contents are undefined; rd_data is 0 only for an out-of-range rd_index.
- Reset mid-burst: tready drops immediately. Partial status is discarded. The upstream master must itself be reset or restarted.
- start sampled on cycle N -> state is RECEIVE and tready = 1 on cycle N+1.
- tready is a decode of the registered state, with no combinational path from tvalid.
- A beat accepted on edge E updates beat_count, error_count and the memory visible after E.
- After the last beat is accepted on edge E:
  - DONE and done = 1 in the cycle after E.
  - tready = 0 in that same cycle.
- tvalid gaps are allowed. No beat is lost or double-counted when tvalid toggles every cycle.
- expected_base changes after start have no effect on the current burst.

## Test plan
- Normal burst
  - Stimulus: start, expected_base = 0x0000FF00; master sends 0xFF00..0xFF07 with TLAST on beat 7, tvalid held high.
  - Required response: done and pass at the 9th cycle after start; error_count = 0; first_error_index = 8; rd_data at rd_index 0..7 = 0xFF00 + i.
- Corrupt beat
  - Stimulus: base 0x0000FF00; beat 3 sent as 0xDEAD; tvalid alternates 1/0 throughout.
  - Required response: error_count = 1; first_error_index = 3; pass = 0; beat_count = 8; rd_data[3] = 0xDEAD.
- Early TLAST
  - Stimulus: TLAST on beat 5 and not on beat 7; data otherwise correct.
  - Required response: tlast_error = 1; error_count = 0; done only after the 8th beat; pass = 0.
- Wrap-around
  - Stimulus: base 0xFFFFFFFC; beats 0xFFFFFFFC, 0xFFFFFFFD, 0xFFFFFFFE, 0xFFFFFFFF, 0, 1, 2, 3.
  - Required response: pass = 1.
- Reset mid-burst and restart
  - Stimulus: deassert ARESETN after 4 beats.
  - Required response: tready, done and beat_count = 0 immediately, with no clock edge needed.
  - Then: release reset, start with base 0x0000CD00, send a correct burst -> pass = 1; rd_data[i] = 0xCD00 + i.
- start while busy, then back-to-back bursts
  - Stimulus: pulse start at beat 2 with base 0x1234.
  - Required response: the pulse is ignored and the burst still checks against the original base.
  - Then: start from DONE with base 0xA0A0A0A0, send a correct burst -> status cleared, then pass = 1 after 8 beats.

Source files
------------

// File: rtl/axis_burst_checker.sv
// axis_burst_checker: AXI4-Stream sink that consumes one fixed-length burst,
// checks each beat against an incrementing pattern (base + beat index),
// checks TLAST placement and stores every received word for readback.
//
// Handshake: a beat transfers on a rising edge where s_axis_tvalid and
// s_axis_tready are both high. s_axis_tready is a pure decode of the
// registered state (high only in RECEIVE) and never looks at tvalid; tdata
// and tlast are only meaningful while tvalid is high.
module axis_burst_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   expected_base,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tlast,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [7:0]              error_count,
  output logic [7:0]              first_error_index,
  output logic                    tlast_error,
  output logic [7:0]              beat_count,
  input  logic [7:0]              rd_index,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [1:0]              state_dbg
);

  localparam int         AW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [7:0] LEN8     = 8'(BURST_LEN);
  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECEIVE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] base_q, base_d;
  logic [7:0]            beat_q, beat_d;
  logic [7:0]            err_q, err_d;
  logic [7:0]            first_q, first_d;
  logic                  tlerr_q, tlerr_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] mem_q [BURST_LEN];

  logic                  accept;
  logic                  is_last;
  logic [DATA_WIDTH-1:0] exp_word;

  // Strobes carry no meaning for this checker.
  logic unused_tstrb;
  assign unused_tstrb = ^s_axis_tstrb;

  assign accept   = (state_q == S_RECEIVE) && s_axis_tvalid;
  assign is_last  = (beat_q == LAST_IDX);
  assign exp_word = base_q + DATA_WIDTH'(beat_q);

  // Next-state and status update: arm on start, score each accepted beat.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    err_d   = err_q;
    first_d = first_q;
    tlerr_d = tlerr_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RECEIVE;
          base_d  = expected_base;
          beat_d  = '0;
          err_d   = '0;
          first_d = LEN8;
          tlerr_d = 1'b0;
          done_d  = 1'b0;
        end
      end
      S_RECEIVE: begin
        if (accept) begin
          beat_d = beat_q + 8'd1;
          if (s_axis_tdata != exp_word) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (first_q == LEN8) first_d = beat_q;
          end
          if (s_axis_tlast != is_last) tlerr_d = 1'b1;
          // Early TLAST does not end the burst; only the beat count does.
          if (is_last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and status registers with asynchronous active-low reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      err_q   <= '0;
      first_q <= LEN8;
      tlerr_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      first_q <= first_d;
      tlerr_q <= tlerr_d;
      done_q  <= done_d;
    end
  end

  // Capture memory: written beat by beat, never cleared.
  always_ff @(posedge ACLK) begin
    if (accept) mem_q[beat_q[AW-1:0]] <= s_axis_tdata;
  end

  // Indexed readback; out-of-range indices read as zero.
  always_comb begin
    rd_data = '0;
    if (rd_index < LEN8) rd_data = mem_q[rd_index[AW-1:0]];
  end

  assign s_axis_tready     = (state_q == S_RECEIVE);
  assign busy              = (state_q == S_RECEIVE);
  assign done              = done_q;
  assign pass              = done_q && (err_q == 8'd0) && !tlerr_q;
  assign error_count       = err_q;
  assign first_error_index = first_q;
  assign tlast_error       = tlerr_q;
  assign beat_count        = beat_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_axis_burst_checker.sv
// Bench for axis_burst_checker: directed bursts, status checks against a
// small reference model and capture-memory checks from an expected queue.
module tb_axis_burst_checker;

  localparam int DW = 32;
  localparam int BL = 8;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] expected_base = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [3:0]    s_axis_tstrb = 4'hF;
  logic          s_axis_tlast = 1'b0;
  logic          busy, done, pass, tlast_error;
  logic [7:0]    error_count, first_error_index, beat_count;
  logic [7:0]    rd_index = '0;
  logic [DW-1:0] rd_data;
  logic [1:0]    state_dbg;

  axis_burst_checker #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .expected_base(expected_base),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
    .s_axis_tlast(s_axis_tlast), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_error_index(first_error_index),
    .tlast_error(tlast_error), .beat_count(beat_count),
    .rd_index(rd_index), .rd_data(rd_data), .state_dbg(state_dbg)
  );

  // Clock
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  // Reference model of the burst status
  int   m_err;
  int   m_first;
  logic m_tlerr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start at the current negedge; status must be cleared one edge later.
  task automatic do_start(input logic [31:0] base);
    start = 1'b1;
    expected_base = base;
    @(negedge ACLK);
    start = 1'b0;
    expected_base = $urandom;
    m_err = 0;
    m_first = BL;
    m_tlerr = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_tready", 32'(s_axis_tready), 1);
    check("start_done_clr", 32'(done), 0);
    check("start_err_clr", 32'(error_count), 0);
    check("start_tlerr_clr", 32'(tlast_error), 0);
    check("start_first_clr", 32'(first_error_index), BL);
    check("start_beat_clr", 32'(beat_count), 0);
  endtask

  // Drive n_beats beats; bad_idx replaces one beat, start_at pulses start mid-burst.
  task automatic send_burst(input logic [31:0] base, input int bad_idx,
                            input logic [31:0] bad_val, input logic [7:0] tlast_mask,
                            input bit gaps, input int n_beats, input int start_at);
    for (int i = 0; i < n_beats; i++) begin
      logic [31:0] d;
      int n;
      d = (i == bad_idx) ? bad_val : base + 32'(i);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = tlast_mask[i];
      s_axis_tstrb  = 4'($urandom_range(0, 15));
      if (i == start_at) begin
        start = 1'b1;
        expected_base = 32'h0000_1234;
      end
      n = 0;
      while (!s_axis_tready && n < 20) begin
        @(negedge ACLK);
        n++;
      end
      check("tready_wait", 32'(s_axis_tready), 1);
      @(posedge ACLK);
      @(negedge ACLK);
      start = 1'b0;
      exp_q.push_back(d);
      if (d != base + 32'(i)) begin
        m_err++;
        if (m_first == BL) m_first = i;
      end
      if (tlast_mask[i] != (i == BL - 1)) m_tlerr = 1'b1;
      check("beat_count", 32'(beat_count), 32'(i + 1));
      check("done_timing", 32'(done), 32'(i == BL - 1));
      if (gaps) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = $urandom;
        s_axis_tlast  = 1'($urandom_range(0, 1));
        @(negedge ACLK);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_status();
    check("st_done", 32'(done), 1);
    check("st_pass", 32'(pass), 32'(m_err == 0 && !m_tlerr));
    check("st_err", 32'(error_count), 32'(m_err));
    check("st_first", 32'(first_error_index), 32'(m_first));
    check("st_tlerr", 32'(tlast_error), 32'(m_tlerr));
    check("st_beats", 32'(beat_count), BL);
    check("st_busy", 32'(busy), 0);
    check("st_tready", 32'(s_axis_tready), 0);
  endtask

  // Pop the scoreboard against the capture memory.
  task automatic drain_sb();
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      rd_index = 8'(i);
      #1;
      check("rd_data", rd_data, exp_q.pop_front());
    end
    @(negedge ACLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge ACLK);
    check("rst_tready", 32'(s_axis_tready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_tlerr", 32'(tlast_error), 0);
    check("rst_err", 32'(error_count), 0);
    check("rst_beats", 32'(beat_count), 0);
    check("rst_first", 32'(first_error_index), BL);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Normal burst, tvalid held high
    do_start(32'h0000_FF00);
    send_burst(32'h0000_FF00, -1, 0, 8'h80, 1'b0, BL, -1);
    check_status();
    drain_sb();

    // Corrupt beat 3 with alternating tvalid
    do_start(32'h0000_FF00);
    send_burst(32'h0000_FF00, 3, 32'h0000_DEAD, 8'h80, 1'b1, BL, -1);
    check_status();
    drain_sb();

    // Early TLAST on beat 5, none on beat 7
    do_start(32'h0000_0100);
    send_burst(32'h0000_0100, -1, 0, 8'h20, 1'b0, BL, -1);
    check_status();
    drain_sb();

    // Wrap-around of the expected pattern
    do_start(32'hFFFF_FFFC);
    send_burst(32'hFFFF_FFFC, -1, 0, 8'h80, 1'b0, BL, -1);
    check_status();
    drain_sb();

    // Reset mid-burst, then a clean restart
    do_start(32'h0000_0500);
    send_burst(32'h0000_0500, -1, 0, 8'h80, 1'b0, 4, -1);
    ARESETN = 1'b0;
    #1;
    check("midrst_tready", 32'(s_axis_tready), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_beats", 32'(beat_count), 0);
    check("midrst_first", 32'(first_error_index), BL);
    exp_q.delete();
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    do_start(32'h0000_CD00);
    send_burst(32'h0000_CD00, -1, 0, 8'h80, 1'b0, BL, -1);
    check_status();
    drain_sb();

    // start pulsed at beat 2 is ignored
    do_start(32'h0000_7700);
    send_burst(32'h0000_7700, -1, 0, 8'h80, 1'b0, BL, 2);
    check_status();
    drain_sb();

    // Back-to-back start from DONE
    do_start(32'hA0A0_A0A0);
    send_burst(32'hA0A0_A0A0, -1, 0, 8'h80, 1'b1, BL, -1);
    check_status();
    drain_sb();

    // Out-of-range readback
    rd_index = 8'(BL);
    #1;
    check("rd_oor_len", rd_data, 0);
    rd_index = 8'd200;
    #1;
    check("rd_oor_200", rd_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
